// File: rtl/sd_pkg.sv
// Shared SD host definitions: receiver state encoding, CRC7 step and response constants.
package sd_pkg;

  localparam int         SD_FRAME_W = 48;
  localparam logic [6:0] CRC7_POLY  = 7'h09;  // x^7 + x^3 + 1, x^7 term implicit

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SHIFT,
    ST_CHECK,
    ST_HOLD
  } rx_state_t;

  // R3 carries no valid CRC, so the issuer sets crc_skip for it.
  typedef enum logic [1:0] {
    RESP_R1 = 2'd0,
    RESP_R3 = 2'd1,
    RESP_R7 = 2'd2
  } resp_type_t;

  // One serial CRC7 step: shift left, fold the poly in when the outgoing bit differs from din.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker, one bit per clock, MSB first. Shared with the command sender.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // CRC register: clear wins over enable so a new frame always starts from zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_resp_rx.sv
// Host-side SD response receiver: hunts for the start bit, deserialises a 48-bit frame,
// checks framing and CRC7, and holds the result until the consumer accepts it.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int FRAME_W   = SD_FRAME_W,
  parameter int TIMEOUT   = 64,
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic               SD_CLK,
  input  logic               rst,
  input  logic               start,
  input  logic               crc_skip,
  input  logic               sd_dout,
  output logic [FRAME_W-1:0] resp_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               busy,
  output logic               timeout,
  output logic               frame_err,
  output logic               crc_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  rx_state_t          state, state_nxt;
  logic [FRAME_W-1:0] shreg;
  logic [5:0]         bitcnt;
  logic [TMR_W-1:0]   timer;
  logic               skip_q;
  logic [6:0]         crc;
  logic               crc_clr;
  logic               crc_en;

  // The start bit (always 0) lands in the top of shreg implicitly because shreg is zeroed on
  // detection and then shifted FRAME_W-1 times; the CRC is fed frame bits [FRAME_W-1:8].
  assign crc_clr = (state == ST_IDLE) && start;
  assign crc_en  = ((state == ST_HUNT) && !sd_dout) ||
                   ((state == ST_SHIFT) && (bitcnt >= 6'd9));

  sd_crc7 u_crc7 (
    .clk (SD_CLK),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (sd_dout),
    .crc (crc)
  );

  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_HOLD);

  // State register.
  always_ff @(posedge SD_CLK) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_HUNT;
      ST_HUNT: begin
        if (!sd_dout)                   state_nxt = ST_SHIFT;
        else if (timer == TMR_W'(1))    state_nxt = ST_HOLD;
      end
      ST_SHIFT: if (bitcnt == 6'd1) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_HOLD;
      ST_HOLD:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: timer, shifter, bit counter and the result registers held through HOLD.
  always_ff @(posedge SD_CLK) begin
    // NOTE: every datapath register is reset so a partial frame can never leak into resp_data.
    if (rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      timer     <= '0;
      skip_q    <= 1'b0;
      resp_data <= '0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            timer     <= TMR_W'(TIMEOUT);
            skip_q    <= crc_skip;
            resp_data <= '0;
            timeout   <= 1'b0;
            frame_err <= 1'b0;
            crc_err   <= 1'b0;
          end
        end
        ST_HUNT: begin
          if (!sd_dout) begin
            shreg  <= '0;
            bitcnt <= 6'(FRAME_W - 1);
          end else begin
            timer <= timer - 1'b1;
            if (timer == TMR_W'(1)) begin
              timeout   <= 1'b1;
              resp_data <= '0;
            end
          end
        end
        ST_SHIFT: begin
          shreg  <= {shreg[FRAME_W-2:0], sd_dout};
          bitcnt <= bitcnt - 1'b1;
        end
        ST_CHECK: begin
          resp_data <= shreg;
          frame_err <= shreg[FRAME_W-2] | ~shreg[0];
          crc_err   <= CHECK_CRC & ~skip_q & (crc != shreg[7:1]);
        end
        default: ;
      endcase
    end
  end

endmodule
